fsk_tone_ctrl: RTL and testbench

Sequencing controller for the FSK transmitter's tone generation, built on the same in_clk-divided tone and symbol-rate scheme as the existing clock dividers. Holds programmable half-periods for the two tones and the symbol length, accepts a bit stream over a valid/ready handshake, and emits one tone per symbol with a symbol-boundary tick. Sits between the bit source (framer) and the modulator output stage; replaces free-running fixed-ratio tone clocks with per-symbol scheduled ones.

---
 rtl/fsk_tone_ctrl.sv | 143 ++++++++++++++
 tb/tb_fsk_tone_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsk_tone_ctrl.sv
// FSK tone sequencer: one tone per symbol, symbol tick, underrun flag.
// Define FSK_CONT_PHASE_EN to keep the tone level across symbol loads.
module fsk_tone_ctrl #(
  parameter int DIV_W    = 11,
  parameter int DIV1_DEF = 4,
  parameter int DIV2_DEF = 8,
  parameter int SYM_DEF  = 1024
) (
  input  logic             in_clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_sel,
  input  logic [DIV_W-1:0] cfg_data,
  input  logic             start,
  input  logic             stop,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             bit_in,
  output logic             tone_out,
  output logic             sym_tick,
  output logic             underrun,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, LOAD, SYM} state_t;

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

  state_t           state, state_nx;
  logic [DIV_W-1:0] div1, div2, sym_len;
  logic [DIV_W-1:0] sym_cnt, tone_cnt;
  logic [DIV_W-1:0] h_cur, h_new;
  logic             cur_bit, stop_pend, stop_req;
  logic             load, to_idle, to_load, cfg_wr;

  assign h_cur = cur_bit ? div2 : div1;
  assign h_new = bit_in ? div2 : div1;
  assign busy  = (state != IDLE);

  always_ff @(posedge in_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cfg_ready = 1'b0;
    bit_ready = 1'b0;
    sym_tick  = 1'b0;
    load      = 1'b0;
    to_idle   = 1'b0;
    to_load   = 1'b0;
    cfg_wr    = 1'b0;
    stop_req  = stop_pend | stop;
    unique case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        cfg_wr    = cfg_valid;
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        bit_ready = ~stop_req;
        if (stop_req) begin
          to_idle  = 1'b1;
          state_nx = IDLE;
        end else if (bit_valid) begin
          load     = 1'b1;
          state_nx = SYM;
        end
      end
      SYM: begin
        if (sym_cnt == ONE) begin
          sym_tick  = 1'b1;
          bit_ready = ~stop_req;
          if (stop_req) begin
            to_idle  = 1'b1;
            state_nx = IDLE;
          end else if (bit_valid) begin
            load = 1'b1;
          end else begin
            to_load  = 1'b1;
            state_nx = LOAD;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Zero would stall the down-counters, so it is clamped on write.
  always_ff @(posedge in_clk or posedge reset) begin
    if (reset) begin
      div1    <= DIV_W'(DIV1_DEF);
      div2    <= DIV_W'(DIV2_DEF);
      sym_len <= DIV_W'(SYM_DEF);
    end else if (cfg_wr) begin
      unique case (cfg_sel)
        2'd0: div1 <= (cfg_data == '0) ? ONE : cfg_data;
        2'd1: div2 <= (cfg_data == '0) ? ONE : cfg_data;
        2'd2: sym_len <= (cfg_data < TWO) ? TWO : cfg_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge in_clk or posedge reset) begin
    if (reset) begin
      sym_cnt   <= '0;
      tone_cnt  <= '0;
      cur_bit   <= 1'b0;
      tone_out  <= 1'b0;
      underrun  <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      underrun <= to_load;
      if (to_idle || state == IDLE) stop_pend <= 1'b0;
      else if (stop)                stop_pend <= 1'b1;
      if (load) begin
        cur_bit  <= bit_in;
        sym_cnt  <= sym_len;
        tone_cnt <= h_new;
`ifdef FSK_CONT_PHASE_EN
        tone_out <= tone_out;
`else
        tone_out <= 1'b0;
`endif
      end else if (state == SYM && !to_idle && !to_load) begin
        sym_cnt <= sym_cnt - ONE;
        if (tone_cnt == ONE) begin
          tone_out <= ~tone_out;
          tone_cnt <= h_cur;
        end else begin
          tone_cnt <= tone_cnt - ONE;
        end
      end else begin
        tone_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fsk_tone_ctrl.sv
// Bench for fsk_tone_ctrl: directed scenarios plus random traffic
// against a symbol-age based reference model.
module tb_fsk_tone_ctrl;
  localparam int W = 11;
`ifdef FSK_CONT_PHASE_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic         in_clk = 1'b0;
  logic         reset = 1'b1;
  logic         cfg_valid = 1'b0;
  logic [1:0]   cfg_sel = '0;
  logic [W-1:0] cfg_data = '0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         bit_valid = 1'b0;
  logic         bit_in = 1'b0;
  logic         cfg_ready, bit_ready, tone_out;
  logic         sym_tick, underrun, busy;

  int n_chk = 0;
  int n_fail = 0;

  // model: 0 idle, 1 waiting for bit, 2 in symbol
  int m_st, m_div1, m_div2, m_sym;
  int cur_h, cur_sym, age;
  bit base, m_stop, m_under;

  always #5 in_clk = ~in_clk;

  fsk_tone_ctrl dut (
    .in_clk    (in_clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_sel   (cfg_sel),
    .cfg_data  (cfg_data),
    .start     (start),
    .stop      (stop),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .bit_in    (bit_in),
    .tone_out  (tone_out),
    .sym_tick  (sym_tick),
    .underrun  (underrun),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit e_tick();
    return (m_st == 2) && (age == cur_sym - 1);
  endfunction

  function automatic bit e_tone();
    if (m_st != 2) return 1'b0;
    return base ^ bit'((age / cur_h) % 2);
  endfunction

  function automatic bit e_bready();
    return ((m_st == 1) || e_tick()) && !(m_stop || stop);
  endfunction

  task automatic model_reset();
    m_st = 0; m_div1 = 4; m_div2 = 8; m_sym = 1024;
    cur_h = 1; cur_sym = 2; age = 0;
    base = 1'b0; m_stop = 1'b0; m_under = 1'b0;
  endtask

  task automatic accept(input bit b0);
    cur_sym = m_sym;
    cur_h   = bit_in ? m_div2 : m_div1;
    age     = 0;
    base    = b0;
    m_st    = 2;
  endtask

  task automatic model_edge();
    bit tk, sr, tn;
    if (reset) begin
      model_reset();
      return;
    end
    tk = e_tick();
    sr = m_stop || stop;
    tn = e_tone();
    m_under = 1'b0;
    case (m_st)
      0: begin
        if (cfg_valid) begin
          case (cfg_sel)
            2'd0: m_div1 = (cfg_data == 0) ? 1 : int'(cfg_data);
            2'd1: m_div2 = (cfg_data == 0) ? 1 : int'(cfg_data);
            2'd2: m_sym = (cfg_data < 2) ? 2 : int'(cfg_data);
            default: ;
          endcase
        end
        m_stop = 1'b0;
        if (start) m_st = 1;
      end
      1: begin
        if (sr) begin
          m_st = 0; m_stop = 1'b0;
        end else if (bit_valid) begin
          accept(1'b0);
        end
      end
      default: begin
        if (!tk) begin
          age++;
          if (stop) m_stop = 1'b1;
        end else if (sr) begin
          m_st = 0; m_stop = 1'b0;
        end else if (bit_valid) begin
          accept(CONT ? tn : 1'b0);
        end else begin
          m_st = 1; m_under = 1'b1;
        end
      end
    endcase
  endtask

  task automatic step();
    @(negedge in_clk);
    check("cfg_ready", 32'(cfg_ready), 32'(m_st == 0));
    check("busy", 32'(busy), 32'(m_st != 0));
    check("bit_ready", 32'(bit_ready), 32'(e_bready()));
    check("sym_tick", 32'(sym_tick), 32'(e_tick()));
    check("tone_out", 32'(tone_out), 32'(e_tone()));
    check("underrun", 32'(underrun), 32'(m_under));
    @(posedge in_clk);
    model_edge();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cfg_write(input logic [1:0] s, input int d);
    cfg_valid = 1'b1; cfg_sel = s; cfg_data = W'(d);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic go();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  // Offer one bit until the model says it was taken.
  task automatic feed(input bit b);
    bit acc;
    bit_valid = 1'b1; bit_in = b;
    acc = 1'b0;
    for (int i = 0; i < 2100 && !acc; i++) begin
      acc = e_bready();
      step();
    end
    if (!acc) check("feed_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit_valid = 1'b0;
    for (int i = 0; i < 2100 && m_st != 0; i++) step();
    check("idle_reached", 32'(m_st), 0);
  endtask

  initial begin
    model_reset();
    run(2);
    reset = 1'b0;
    run(2);

    // sym=0 clamps to 2
    cfg_write(2'd2, 0);
    go();
    feed(1'b0); feed(1'b0); feed(1'b1);
    bit_valid = 1'b0;
    run(4);
    pulse_stop();
    run(2);

    // two tones back to back, then underrun
    cfg_write(2'd2, 16);
    cfg_write(2'd0, 2);
    cfg_write(2'd1, 4);
    go();
    feed(1'b0); feed(1'b1);
    bit_valid = 1'b0;
    run(24);
    pulse_stop();
    run(2);

    // stop at cycle 5 of a symbol
    go();
    feed(1'b0);
    bit_valid = 1'b1; bit_in = 1'b1;
    run(4);
    pulse_stop();
    run(16);
    wait_idle();

    // phase handling across a load
    cfg_write(2'd1, 3);
    cfg_write(2'd2, 9);
    go();
    feed(1'b1); feed(1'b1);
    run(12);
    pulse_stop();
    wait_idle();

    // reset mid-symbol
    cfg_write(2'd0, 2);
    cfg_write(2'd2, 16);
    go();
    feed(1'b0);
    bit_valid = 1'b1;
    run(6);
    reset = 1'b1; bit_valid = 1'b0;
    #1;
    check("rst_cfg_ready", 32'(cfg_ready), 1);
    check("rst_bit_ready", 32'(bit_ready), 0);
    check("rst_tone", 32'(tone_out), 0);
    check("rst_tick", 32'(sym_tick), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_busy", 32'(busy), 0);
    model_reset();
    run(2);
    reset = 1'b0;
    go();
    feed(1'b0);
    bit_valid = 1'b0;
    run(30);
    pulse_stop();
    wait_idle();

    // random traffic
    for (int i = 0; i < 5000; i++) begin
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_sel   = 2'($urandom_range(0, 3));
      cfg_data  = W'($urandom_range(0, 12));
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 40) == 0);
      bit_valid = ($urandom_range(0, 9) != 0);
      bit_in    = 1'($urandom_range(0, 1));
      step();
    end
    cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    pulse_stop();
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
